// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_access_ctrl : M-stage load/store sequencer with pipeline stall and
//                    lane-aligned, sign/zero-extended load return.
// Revision: 1.0
// ============================================================================
module dmem_access_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_accessM,
    input  logic [6:0]      opcodeM,
    input  logic [2:0]      funct3M,
    input  logic [XLEN-1:0] alu_outM,
    input  logic [XLEN-1:0] forward_rs2M,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_req_we,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [XLEN-1:0] dmem_req_wdata,
    output logic [3:0]      dmem_req_be,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_rdata,
    output logic            stallM,
    output logic            load_validM,
    output logic [XLEN-1:0] load_dataM,
    output logic            mem_faultM
);

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic [XLEN-3:0]   r_word;
    logic [XLEN-1:0]   r_wdata;
    logic [3:0]        r_be;
    logic [XLEN-1:0]   r_load_data;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_f3_ok;
    logic              w_align_ok;
    logic              w_legal;
    logic              w_start;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load_ext;

    assign w_is_load  = (opcodeM == c_OP_LOAD);
    assign w_is_store = (opcodeM == c_OP_STORE);

    always_comb begin
        w_f3_ok = 1'b0;
        if (w_is_load) begin
            case (funct3M)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
                default:                                w_f3_ok = 1'b0;
            endcase
        end else if (w_is_store) begin
            case (funct3M)
                3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
                default:                w_f3_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (funct3M[1:0])
            2'b01:   w_align_ok = ~alu_outM[0];
            2'b10:   w_align_ok = (alu_outM[1:0] == 2'b00);
            default: w_align_ok = 1'b1;
        endcase
    end

    assign w_legal = w_f3_ok & w_align_ok;

    // Gated by rst_n so stall/fault read 0 while reset is held, even if the
    // pipeline keeps presenting an access.
    assign w_start    = rst_n & (r_state == ST_IDLE) & mem_accessM & w_legal;
    assign mem_faultM = rst_n & (r_state == ST_IDLE) & mem_accessM & ~w_legal;

    always_comb begin
        case (funct3M[1:0])
            2'b00: begin
                w_be    = 4'b0001 << alu_outM[1:0];
                w_wdata = {(XLEN/8){forward_rs2M[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << alu_outM[1:0];
                w_wdata = {(XLEN/16){forward_rs2M[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = forward_rs2M;
            end
        endcase
    end

    assign w_byte = dmem_rsp_rdata[{r_off, 3'b000} +: 8];
    assign w_half = dmem_rsp_rdata[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_ext = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_ext = dmem_rsp_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_word      <= '0;
            r_wdata     <= '0;
            r_be        <= 4'b0000;
            r_load_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state  <= ST_REQ;
                        r_we     <= w_is_store;
                        r_funct3 <= funct3M;
                        r_off    <= alu_outM[1:0];
                        r_word   <= alu_outM[XLEN-1:2];
                        r_wdata  <= w_wdata;
                        r_be     <= w_be;
                    end
                end
                ST_REQ: begin
                    if (dmem_req_ready) begin
                        r_state <= r_we ? ST_DONE : ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        r_load_data <= w_load_ext;
                        r_state     <= ST_DONE;
                    end
                end
                // mem_accessM still belongs to the retiring instruction here.
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dmem_req_valid = (r_state == ST_REQ);
    assign dmem_req_we    = r_we;
    assign dmem_req_addr  = {r_word, 2'b00};
    assign dmem_req_wdata = r_wdata;
    assign dmem_req_be    = r_be;
    assign stallM         = w_start | (r_state == ST_REQ) | (r_state == ST_WAIT_RSP);
    assign load_validM    = (r_state == ST_DONE) & ~r_we;
    assign load_dataM     = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dmem_access_ctrl : directed + randomized bench against a byte-level model.
// Revision: 1.0
// ============================================================================
module tb_dmem_access_ctrl;

    localparam logic [6:0] c_LOAD  = 7'b0000011;
    localparam logic [6:0] c_STORE = 7'b0100011;
    localparam logic [6:0] c_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_accessM = 1'b0;
    logic [6:0]  opcodeM = '0;
    logic [2:0]  funct3M = '0;
    logic [31:0] alu_outM = '0;
    logic [31:0] forward_rs2M = '0;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_be;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rsp_rdata = '0;
    logic        stallM;
    logic        load_validM;
    logic [31:0] load_dataM;
    logic        mem_faultM;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_load = '0;

    dmem_access_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_accessM(mem_accessM), .opcodeM(opcodeM),
        .funct3M(funct3M), .alu_outM(alu_outM), .forward_rs2M(forward_rs2M),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
        .stallM(stallM), .load_validM(load_validM), .load_dataM(load_dataM),
        .mem_faultM(mem_faultM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
        if (op == c_LOAD) begin
            if (f3 == 3 || f3 == 6 || f3 == 7) return 0;
        end else if (op == c_STORE) begin
            if (f3 > 2) return 0;
        end else begin
            return 0;
        end
        return (a % m_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r = '0;
        int sz = m_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int sz = m_size(f3);
        logic [31:0] v = rd >> (8 * (a % 4));
        logic [31:0] mask;
        if (sz == 4) return rd;
        mask = (32'd1 << (8 * sz)) - 1;
        v = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- one M-stage instruction ----------------
    task automatic access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rs2, input logic [31:0] rd,
                          input int rdy_dly, input int rsp_dly);
        bit legal = m_legal(op, f3, a);
        bit is_load = (op == c_LOAD);
        int k = 0, ka = -1, stalls = 0, reqs = 0;
        bit done = 0, seen_req = 0;
        logic timed_out;
        @(posedge clk); #1;
        mem_accessM = 1'b1; opcodeM = op; funct3M = f3; alu_outM = a;
        forward_rs2M = rs2; dmem_rsp_rdata = rd;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        @(negedge clk);
        check("start_valid", 32'(dmem_req_valid), 32'd0);
        check("start_fault", 32'(mem_faultM), 32'(!legal));
        check("start_stall", 32'(stallM), 32'(legal));
        if (!legal) begin
            check("fault_ldata", load_dataM, last_load);
            return;
        end
        stalls = 1;
        while (!done && k < 60) begin
            @(posedge clk); #1;
            k++;
            dmem_req_ready = (k > rdy_dly);
            dmem_rsp_valid = (ka >= 0 && k == ka + rsp_dly);
            @(negedge clk);
            if (dmem_req_valid) begin
                if (!seen_req) begin
                    check("req_addr", dmem_req_addr, a & ~32'd3);
                    check("req_we", 32'(dmem_req_we), 32'(!is_load));
                    check("req_be", 32'(dmem_req_be), 32'(m_be(f3, a)));
                    if (!is_load) check("req_wdata", dmem_req_wdata, m_wdata(f3, rs2));
                    seen_req = 1;
                end
                if (dmem_req_ready) begin
                    reqs++;
                    ka = k;
                end
            end
            if (stallM) stalls++;
            else begin
                done = 1;
                if (is_load) last_load = m_load(f3, a, rd);
                check("done_lvalid", 32'(load_validM), 32'(is_load));
                check("done_ldata", load_dataM, last_load);
            end
        end
        timed_out = !done;
        check("timeout", 32'(timed_out), 32'd0);
        check("req_count", 32'(reqs), 32'd1);
        check("stall_cycles", 32'(stalls), 32'(1 + rdy_dly + 1 + (is_load ? rsp_dly : 0)));
        dmem_rsp_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            mem_accessM = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
            @(negedge clk);
            check("idle_lvalid", 32'(load_validM), 32'd0);
            check("idle_stall", 32'(stallM), 32'd0);
        end
    endtask

    initial begin
        logic [6:0] op;
        // reset state
        #12;
        check("rst_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_stall", 32'(stallM), 32'd0);
        check("rst_fault", 32'(mem_faultM), 32'd0);
        check("rst_lvalid", 32'(load_validM), 32'd0);
        check("rst_ldata", load_dataM, 32'd0);
        check("rst_be", 32'(dmem_req_be), 32'd0);
        check("rst_addr", dmem_req_addr, 32'd0);
        check("rst_wdata", dmem_req_wdata, 32'd0);
        check("rst_we", 32'(dmem_req_we), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);

        // directed cases
        access(c_STORE, 3'b000, 32'h1003, 32'hAABBCCDD, 32'h0, 0, 1);
        check("sb_be_lit", 32'(dmem_req_be), 32'h8);
        check("sb_wdata_lit", dmem_req_wdata, 32'hDDDDDDDD);
        idle(1);
        access(c_LOAD, 3'b000, 32'h2001, 32'h0, 32'h1234F678, 0, 1);
        check("lb_lit", load_dataM, 32'hFFFFFFF6);
        access(c_LOAD, 3'b100, 32'h2001, 32'h0, 32'h1234F678, 0, 1);
        check("lbu_lit", load_dataM, 32'h000000F6);
        idle(1);
        access(c_LOAD, 3'b001, 32'h2002, 32'h0, 32'h8001FFFF, 3, 2);
        check("lh_lit", load_dataM, 32'hFFFF8001);
        idle(1);
        access(c_LOAD, 3'b010, 32'h3002, 32'h0, 32'h0, 0, 1);
        access(c_STORE, 3'b001, 32'h3001, 32'h1234, 32'h0, 0, 1);
        idle(1);
        access(c_STORE, 3'b010, 32'h4000, 32'hCAFEF00D, 32'h0, 1, 1);
        access(c_LOAD, 3'b010, 32'h4000, 32'h0, 32'hCAFEF00D, 0, 3);
        idle(1);

        // async reset while a request is outstanding
        @(posedge clk); #1;
        mem_accessM = 1'b1; opcodeM = c_LOAD; funct3M = 3'b010; alu_outM = 32'h5000;
        dmem_req_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", 32'(dmem_req_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(dmem_req_valid), 32'd0);
        check("arst_stall", 32'(stallM), 32'd0);
        check("arst_be", 32'(dmem_req_be), 32'd0);
        @(posedge clk); #1;
        mem_accessM = 1'b0; rst_n = 1'b1;
        last_load = '0;
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("post_rst_valid", 32'(dmem_req_valid), 32'd0);
        idle(3);
        check("post_rst_ldata", load_dataM, 32'd0);

        // randomized accesses
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0:       op = c_ALU;
                1, 2, 3, 4: op = c_STORE;
                default: op = c_LOAD;
            endcase
            access(op, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage data-memory access controller for the 3-stage RISC-V core. It sits after the execute/memory pipeline register and consumes its M-stage outputs: address from the ALU result, store data from the forwarded rs2, funct3 and opcode. It sequences one load or store per instruction over a valid/ready request channel and a valid response channel. While an access is outstanding it stalls the upstream pipeline registers, and it returns lane-aligned, sign- or zero-extended load data.

## Interface
- XLEN, 32, data/address width (equals `XLEN`)
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_accessM  in  1  M-stage instruction is a load or store
- opcodeM  in  7  M-stage opcode; 0000011 = load, 0100011 = store
- funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_outM  in  XLEN  byte address
- forward_rs2M  in  XLEN  store data, unaligned (low bits)
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  request accepted when valid && ready
- dmem_req_we  out  1  1 = store
- dmem_req_addr  out  XLEN  word address; bits [1:0] forced to 0
- dmem_req_wdata  out  XLEN  lane-replicated store data
- dmem_req_be  out  4  byte enables
- dmem_rsp_valid  in  1  load response valid, single cycle
- dmem_rsp_rdata  in  XLEN  aligned response word
- stallM  out  1  hold PC and all pipeline registers this cycle
- load_validM  out  1  one-cycle pulse: load_dataM is new and the instruction retires
- load_dataM  out  XLEN  extended load result; holds until the next load completes
- mem_faultM  out  1  one-cycle pulse: misaligned or illegal access; no request issued

## Operation
- States: IDLE, REQ, WAIT_RSP, DONE. Reset state is IDLE.
- Reset values: all outputs 0. load_dataM is 0.
- **IDLE**, access start (mem_accessM && legal):
  - latch address, we, funct3, shaped wdata and be
  - go to REQ; stallM = 1 combinationally in this same cycle
- **IDLE**, mem_accessM && !legal: mem_faultM = 1 for that cycle, stallM = 0, state stays IDLE.
- Illegal accesses:
  - load funct3 ∈ {011, 110, 111}
  - store funct3 ∉ {000, 001, 010}
  - opcode neither load nor store
  - H/HU with addr[0] = 1
  - W with addr[1:0] ≠ 00
- **REQ**: dmem_req_valid = 1; addr, we, wdata and be held stable until the handshake.
  - On handshake, a store goes to DONE and a load goes to WAIT_RSP.
  - stallM = 1.
- **WAIT_RSP**: stallM = 1. On dmem_rsp_valid, capture the extended data into load_dataM and go to DONE.
- **DONE**: stallM = 0, so the pipeline advances at this edge.
  - load_validM = 1 for loads only.
  - Always return to IDLE. mem_accessM is ignored here because it still belongs to the retiring instruction.
- dmem_rsp_valid is ignored in IDLE, REQ and DONE.
- Byte enables, with o = addr[1:0]:
  - B/BU: 0001 << o
  - H/HU: 0011 << o
  - W: 1111
- Store data:
  - SB: {4{rs2[7:0]}}
  - SH: {2{rs2[15:0]}}
  - SW: rs2
- Load extraction: select the byte at rdata[8*o +: 8] or the halfword at rdata[16*o[1] +: 16].
  - B and H are sign-extended to XLEN.
  - BU and HU are zero-extended.
  - W is passed through.
- Asynchronous reset mid-access:
  - state goes to IDLE immediately; valid and stall drop immediately
  - a response arriving after reset is ignored

## Timing
- Store with ready already high: access cycle (IDLE) → REQ (handshake) → DONE. 3 cycles total, stallM high for the first 2.
- Load with ready high and response 1 cycle later: IDLE → REQ → WAIT_RSP (rsp) → DONE. 4 cycles minimum.
- Each cycle of ready low adds one REQ cycle. Each cycle of response delay adds one WAIT_RSP cycle.
- No back-to-back pipelining: at most one outstanding request.
- stallM is a combinational function of state, mem_accessM and legality. There is no registered delay, so the execute/memory register holds in the start cycle.
- load_dataM is registered and is valid in the DONE cycle.

## Test plan
- **Reset:** assert rst_n = 0 mid-REQ with valid = 1 → valid, stallM and be drop to 0 asynchronously; state is IDLE; a later rsp_valid produces no load_validM.
- **SB:** addr 0x1003, rs2 0xAABBCCDD, ready = 1 → req_addr 0x1000, be 1000, wdata 0xDDDDDDDD, we = 1; stallM high for 2 cycles; no load_validM.
- **LB vs LBU:** LB at addr 0x2001, rdata 0x1234F678 → load_dataM 0xFFFFFFF6. LBU at the same address → 0x000000F6. load_validM pulses once in DONE each time.
- **LH with backpressure:** LH at addr 0x2002, ready low for 3 cycles, rsp 2 cycles after accept, rdata 0x8001FFFF → load_dataM 0xFFFF8001. stallM high for exactly 1 + 4 + 2 = 7 cycles.
- **Misaligned:** LW at 0x3002 and SH at 0x3001 → each gives a mem_faultM pulse with dmem_req_valid never asserted and stallM = 0.
- **Back-to-back:** SW 0x4000 then LW 0x4000 in consecutive M instructions → the second request starts only after the first reaches DONE, and the LW issues exactly one request.
